// File: rtl/io_port_fifo_responder.sv
// io_port_fifo_responder: per-port show-ahead FIFOs that back the datapath's
// predicated I/O, with ready flags decoded only from registered counts.

module io_port_fifo #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push_req,
    input  logic                  pop_req,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  nonempty
);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push, pop;

    assign full     = count == FULL_COUNT;
    assign nonempty = count != '0;
    // Full is the pre-cycle value, so a pop never frees room for a same-cycle push.
    assign push     = push_req & ~full;
    assign pop      = pop_req & nonempty;
    assign rdata    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

module io_port_fifo_responder #(
    parameter int WORD_WIDTH = 36,
    parameter int PORT_COUNT = 4,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    output logic [PORT_COUNT-1:0]            read_EF,
    input  logic [PORT_COUNT-1:0]            io_rden,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] io_rdata,
    output logic [PORT_COUNT-1:0]            write_EF,
    input  logic [PORT_COUNT-1:0]            io_wren,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0] io_wdata,
    input  logic [PORT_COUNT-1:0]            in_valid,
    output logic [PORT_COUNT-1:0]            in_ready,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data,
    output logic [PORT_COUNT-1:0]            out_valid,
    input  logic [PORT_COUNT-1:0]            out_ready,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] out_data,
    output logic [PORT_COUNT-1:0]            overflow,
    output logic [PORT_COUNT-1:0]            underflow
);
    logic [PORT_COUNT-1:0] rd_full, wr_full;

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
        io_port_fifo #(.WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd (
            .clock(clock), .reset_n(reset_n),
            .push_req(in_valid[i]), .pop_req(io_rden[i]),
            .wdata(in_data[i*WORD_WIDTH +: WORD_WIDTH]),
            .rdata(io_rdata[i*WORD_WIDTH +: WORD_WIDTH]),
            .full(rd_full[i]), .nonempty(read_EF[i])
        );
        io_port_fifo #(.WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr (
            .clock(clock), .reset_n(reset_n),
            .push_req(io_wren[i]), .pop_req(out_ready[i]),
            .wdata(io_wdata[i*WORD_WIDTH +: WORD_WIDTH]),
            .rdata(out_data[i*WORD_WIDTH +: WORD_WIDTH]),
            .full(wr_full[i]), .nonempty(out_valid[i])
        );
    end

    assign in_ready = ~rd_full;
    assign write_EF = ~wr_full;

    // Sticky predication-bug flags; only reset clears them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= '0;
            underflow <= '0;
        end else begin
            overflow  <= overflow | (io_wren & wr_full);
            underflow <= underflow | (io_rden & ~read_EF);
        end
    end
endmodule

// File: tb/tb_io_port_fifo_responder.sv
// tb_io_port_fifo_responder: directed and random stimulus checked against a
// queue-based model of the per-port FIFOs and sticky error flags.

module tb_io_port_fifo_responder;
    localparam int W = 36;
    localparam int P = 4;
    localparam int D = 4;

    logic           clock = 0;
    logic           reset_n = 0;
    logic [P-1:0]   read_EF, write_EF, in_ready, out_valid, overflow, underflow;
    logic [P-1:0]   io_rden = 0, io_wren = 0, in_valid = 0, out_ready = 0;
    logic [P*W-1:0] io_rdata, out_data;
    logic [P*W-1:0] io_wdata = 0, in_data = 0;

    int total = 0;
    int bad = 0;

    logic [W-1:0] rq [P][$];
    logic [W-1:0] wq [P][$];
    logic [P-1:0] ovf_m = 0, unf_m = 0;

    io_port_fifo_responder #(.WORD_WIDTH(W), .PORT_COUNT(P), .DEPTH(D), .ADDR_WIDTH(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .read_EF(read_EF), .io_rden(io_rden), .io_rdata(io_rdata),
        .write_EF(write_EF), .io_wren(io_wren), .io_wdata(io_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [P-1:0] rdy_e, wef_e, ref_e, ov_e;
        for (int i = 0; i < P; i++) begin
            ref_e[i] = rq[i].size() > 0;
            rdy_e[i] = rq[i].size() < D;
            ov_e[i]  = wq[i].size() > 0;
            wef_e[i] = wq[i].size() < D;
        end
        chk("read_EF", W'(read_EF), W'(ref_e));
        chk("in_ready", W'(in_ready), W'(rdy_e));
        chk("out_valid", W'(out_valid), W'(ov_e));
        chk("write_EF", W'(write_EF), W'(wef_e));
        chk("overflow", W'(overflow), W'(ovf_m));
        chk("underflow", W'(underflow), W'(unf_m));
        for (int i = 0; i < P; i++) begin
            if (rq[i].size() > 0) chk($sformatf("io_rdata[%0d]", i), io_rdata[i*W +: W], rq[i][0]);
            if (wq[i].size() > 0) chk($sformatf("out_data[%0d]", i), out_data[i*W +: W], wq[i][0]);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < P; i++) begin
            int rs = rq[i].size();
            int ws = wq[i].size();
            if (io_rden[i] && rs == 0) unf_m[i] = 1'b1;
            if (io_wren[i] && ws == D) ovf_m[i] = 1'b1;
            if (io_rden[i] && rs > 0) void'(rq[i].pop_front());
            if (in_valid[i] && rs < D) rq[i].push_back(in_data[i*W +: W]);
            if (out_ready[i] && ws > 0) void'(wq[i].pop_front());
            if (io_wren[i] && ws < D) wq[i].push_back(io_wdata[i*W +: W]);
        end
        @(posedge clock);
        #1;
        io_rden = 0; io_wren = 0; in_valid = 0; out_ready = 0;
        check_all();
    endtask

    task automatic model_reset();
        for (int i = 0; i < P; i++) begin
            rq[i].delete();
            wq[i].delete();
        end
        ovf_m = 0;
        unf_m = 0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_all();
        chk("reset write_EF all ones", W'(write_EF), W'(4'hF));
        reset_n = 1;
        tick();

        // Read path on port 1
        in_valid[1] = 1; in_data[1*W +: W] = 36'h11;
        tick();
        chk("rd1 first word", io_rdata[1*W +: W], 36'h11);
        in_valid[1] = 1; in_data[1*W +: W] = 36'h22;
        tick();
        io_rden[1] = 1;
        tick();
        chk("rd1 second word", io_rdata[1*W +: W], 36'h22);
        io_rden[1] = 1;
        tick();
        chk("rd1 empty", W'(read_EF[1]), 0);

        // Full and wrap on port 0, three rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k <= D; k++) begin
                in_valid[0] = 1; in_data[0 +: W] = W'(r * 16 + k + 36'h100);
                tick();
            end
            chk("rd0 in_ready when full", W'(in_ready[0]), 0);
            for (int k = 0; k < D; k++) begin
                chk("rd0 drain order", io_rdata[0 +: W], W'(r * 16 + k + 36'h100));
                io_rden[0] = 1;
                tick();
            end
            chk("rd0 drained", W'(read_EF[0]), 0);
        end

        // Simultaneous pop and push on a full port 2
        for (int k = 0; k < D; k++) begin
            in_valid[2] = 1; in_data[2*W +: W] = W'(36'h200 + k);
            tick();
        end
        io_rden[2] = 1; in_valid[2] = 1; in_data[2*W +: W] = 36'h2AA;
        tick();
        chk("rd2 count D-1 after pop+refused push", W'(in_ready[2]), 1);
        in_valid[2] = 1;
        tick();
        chk("rd2 full again", W'(in_ready[2]), 0);

        // Write path on port 3
        io_wren[3] = 1; io_wdata[3*W +: W] = 36'hABC;
        tick();
        chk("wr3 out_data", out_data[3*W +: W], 36'hABC);
        tick();
        chk("wr3 held stable", out_data[3*W +: W], 36'hABC);
        for (int k = 1; k < D; k++) begin
            io_wren[3] = 1; io_wdata[3*W +: W] = W'(36'hAB0 + k);
            tick();
        end
        chk("wr3 write_EF low when full", W'(write_EF[3]), 0);
        io_wren[3] = 1; io_wdata[3*W +: W] = 36'hDEAD;
        tick();
        chk("wr3 overflow", W'(overflow[3]), 1);
        for (int k = 0; k < D; k++) begin
            out_ready[3] = 1;
            tick();
        end

        // Underflow on empty port 0, then asynchronous reset with data held
        io_rden[0] = 1;
        tick();
        chk("rd0 underflow", W'(underflow[0]), 1);
        for (int k = 0; k < 2; k++) begin
            in_valid = 4'hF; io_wren = 4'hF;
            in_data = {P{W'(36'h500 + k)}}; io_wdata = {P{W'(36'h600 + k)}};
            tick();
        end
        #2 reset_n = 0;
        model_reset();
        #1;
        check_all();
        chk("async reset read_EF", W'(read_EF), 0);
        chk("async reset underflow", W'(underflow), 0);
        #2 reset_n = 1;
        tick();

        // Random traffic on all ports
        for (int n = 0; n < 400; n++) begin
            io_rden = P'($urandom); io_wren = P'($urandom);
            in_valid = P'($urandom); out_ready = P'($urandom);
            for (int i = 0; i < P; i++) begin
                in_data[i*W +: W] = {4'($urandom), 32'($urandom)};
                io_wdata[i*W +: W] = {4'($urandom), 32'($urandom)};
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
